// File: rtl/jump_controller_if.sv
// Handshake and status bundle between the mode/command source and the jump controller.
// master: drives mode, jump_valid, jump_target; slave: drives ready, pos_mode, position, status.
interface jump_controller_if #(
    parameter int K = 16
);
    logic [3:0]     mode;
    logic           jump_valid;
    logic [3*K-1:0] jump_target;
    logic           jump_ready;
    logic [3:0]     pos_mode;
    logic [3*K-1:0] jump_position;
    logic           busy;
    logic           jump_done;
    logic           jump_abort;

    modport master (
        output mode,
        output jump_valid,
        output jump_target,
        input  jump_ready,
        input  pos_mode,
        input  jump_position,
        input  busy,
        input  jump_done,
        input  jump_abort
    );

    modport slave (
        input  mode,
        input  jump_valid,
        input  jump_target,
        output jump_ready,
        output pos_mode,
        output jump_position,
        output busy,
        output jump_done,
        output jump_abort
    );
endinterface

// File: rtl/jump_controller.sv
// Jump controller: INIT/IDLE/CHARGE/JUMP/COOLDOWN sequencer for the position stage.
// Ports: clk, rst_n (async active-low), bus (slave side of jump_controller_if).
module jump_controller #(
    parameter int K               = 16,
    parameter int CHARGE_CYCLES   = 4,
    parameter int COOLDOWN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    jump_controller_if.slave bus
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CHARGE,
        S_JUMP,
        S_COOL
    } state_t;

    localparam logic [7:0] CHG_LD  = 8'(CHARGE_CYCLES - 1);
    localparam logic [7:0] CHG_LD2 = 8'(2 * CHARGE_CYCLES - 1);
    localparam logic [7:0] COOL_LD = 8'(COOLDOWN_CYCLES - 1);

    localparam logic [3:0] PM_RESET  = 4'b0001;
    localparam logic [3:0] PM_NORMAL = 4'b0010;
    localparam logic [3:0] PM_JUMP   = 4'b0100;

    state_t         state_q;
    state_t         state_d;
    logic [7:0]     cnt_q;
    logic [3*K-1:0] position_q;
    logic           abort_q;

    logic mode_rst;
    logic stealth;
    logic take;
    logic cnt_zero;

    // Only exact one-hot values are meaningful; anything else is non-RESET.
    assign mode_rst = (bus.mode == 4'b0001);
    assign stealth  = (bus.mode == 4'b1000);
    assign cnt_zero = (cnt_q == 8'd0);

    // A RESET request in the same cycle wins over the handshake.
    assign take = (state_q == S_IDLE) && bus.jump_valid && !mode_rst;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (mode_rst) begin
            state_d = S_INIT;
        end else begin
            case (state_q)
                S_INIT:   state_d = S_IDLE;
                S_IDLE:   if (bus.jump_valid) state_d = S_CHARGE;
                S_CHARGE: if (cnt_zero) state_d = S_JUMP;
                S_JUMP:   state_d = S_COOL;
                S_COOL:   if (cnt_zero) state_d = S_IDLE;
                default:  state_d = S_INIT;
            endcase
        end
    end

    // Counter, latched target and registered abort pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= 8'd0;
            position_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            // Abort only marks cancelled charges/cooldowns, not idle or jump.
            abort_q <= mode_rst &&
                       ((state_q == S_CHARGE) || (state_q == S_COOL));
            if (take) begin
                position_q <= bus.jump_target;
                cnt_q      <= stealth ? CHG_LD2 : CHG_LD;
            end else if (state_q == S_JUMP) begin
                cnt_q <= COOL_LD;
            end else if (((state_q == S_CHARGE) || (state_q == S_COOL))
                         && !cnt_zero) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    // Moore outputs
    always_comb begin
        bus.pos_mode   = PM_RESET;
        bus.jump_ready = 1'b0;
        bus.busy       = 1'b1;
        bus.jump_done  = 1'b0;
        case (state_q)
            S_INIT: begin
                bus.pos_mode = PM_RESET;
            end
            S_IDLE: begin
                bus.pos_mode   = PM_NORMAL;
                bus.jump_ready = 1'b1;
                bus.busy       = 1'b0;
            end
            S_CHARGE: begin
                bus.pos_mode = PM_NORMAL;
            end
            S_JUMP: begin
                bus.pos_mode  = PM_JUMP;
                bus.jump_done = 1'b1;
            end
            S_COOL: begin
                bus.pos_mode = PM_NORMAL;
            end
            default: begin
                bus.pos_mode = PM_RESET;
            end
        endcase
    end

    assign bus.jump_position = position_q;
    assign bus.jump_abort    = abort_q;

endmodule

// File: tb/tb_jump_controller.sv
// Directed self-checking bench for jump_controller.
// Drives the master side of jump_controller_if and checks outputs 1 time unit after each edge.
module tb_jump_controller;

    localparam int K = 16;

    logic clk;
    logic rst_n;

    int n_chk;
    int n_pass;
    int n;

    jump_controller_if #(.K(K)) bus ();

    jump_controller #(
        .K(K),
        .CHARGE_CYCLES(4),
        .COOLDOWN_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] tgt(input logic [15:0] z,
                                        input logic [15:0] y,
                                        input logic [15:0] x);
        return {z, y, x};
    endfunction

    // Edges until the JUMP cycle is visible; bound of 40.
    task automatic ticks_to_jump(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            cnt++;
            if (bus.pos_mode == 4'b0100) break;
        end
    endtask

    // Cooldown cycles seen before IDLE; bound of 40.
    task automatic ticks_to_idle(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.jump_ready) break;
            cnt++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst_n = 1'b0;
        bus.mode        = 4'b0010;
        bus.jump_valid  = 1'b0;
        bus.jump_target = '0;

        // Reset values
        repeat (2) tick();
        check("rst_pos_mode", 64'(bus.pos_mode), 64'h1);
        check("rst_ready",    64'(bus.jump_ready), 64'h0);
        check("rst_busy",     64'(bus.busy), 64'h1);
        check("rst_done",     64'(bus.jump_done), 64'h0);
        check("rst_abort",    64'(bus.jump_abort), 64'h0);
        check("rst_position", 64'(bus.jump_position), 64'h0);

        // Release: one INIT cycle then IDLE
        rst_n = 1'b1;
        #1;
        check("rel_init", 64'(bus.pos_mode), 64'h1);
        tick();
        check("rel_idle_pm",  64'(bus.pos_mode), 64'h2);
        check("rel_idle_rdy", 64'(bus.jump_ready), 64'h1);
        check("rel_idle_bsy", 64'(bus.busy), 64'h0);
        check("rel_idle_pos", 64'(bus.jump_position), 64'h0);

        // Normal jump {3,2,1}
        bus.jump_valid  = 1'b1;
        bus.jump_target = tgt(16'd3, 16'd2, 16'd1);
        tick();
        bus.jump_valid = 1'b0;
        check("chg_pm",    64'(bus.pos_mode), 64'h2);
        check("chg_ready", 64'(bus.jump_ready), 64'h0);
        check("chg_busy",  64'(bus.busy), 64'h1);
        ticks_to_jump(n);
        check("chg_len", 64'(n), 64'd4);
        check("jmp_done", 64'(bus.jump_done), 64'h1);
        check("jmp_pos",  64'(bus.jump_position), 64'h0003_0002_0001);
        ticks_to_idle(n);
        check("cool_len", 64'(n), 64'd8);
        check("cool_done0", 64'(bus.jump_done), 64'h0);

        // Stealth: doubled charge, mode change mid-charge ignored
        bus.mode        = 4'b1000;
        bus.jump_valid  = 1'b1;
        bus.jump_target = tgt(16'd5, 16'd5, 16'd5);
        tick();
        bus.jump_valid = 1'b0;
        tick();
        bus.mode = 4'b0010;
        ticks_to_jump(n);
        check("stl_chg_len", 64'(n + 1), 64'd8);
        check("stl_done", 64'(bus.jump_done), 64'h1);
        ticks_to_idle(n);
        check("stl_cool_len", 64'(n), 64'd8);

        // Multi-hot mode is not stealth
        bus.mode        = 4'b1001;
        bus.jump_valid  = 1'b1;
        bus.jump_target = tgt(16'd0, 16'd0, 16'd9);
        tick();
        bus.jump_valid = 1'b0;
        ticks_to_jump(n);
        check("mh_chg_len", 64'(n), 64'd4);
        ticks_to_idle(n);
        bus.mode = 4'b0010;

        // RESET during second CHARGE cycle -> abort
        bus.jump_valid  = 1'b1;
        bus.jump_target = tgt(16'd9, 16'd8, 16'd7);
        tick();
        bus.jump_valid = 1'b0;
        tick();
        bus.mode = 4'b0001;
        tick();
        check("ab_pm",    64'(bus.pos_mode), 64'h1);
        check("ab_pulse", 64'(bus.jump_abort), 64'h1);
        check("ab_done",  64'(bus.jump_done), 64'h0);
        tick();
        check("ab_init_hold", 64'(bus.pos_mode), 64'h1);
        check("ab_pulse_end", 64'(bus.jump_abort), 64'h0);
        check("ab_pos_kept",  64'(bus.jump_position), 64'h0009_0008_0007);
        bus.mode = 4'b0000;
        tick();
        check("m0_idle", 64'(bus.jump_ready), 64'h1);
        bus.mode = 4'b0010;
        tick();
        check("ab_idle_pos", 64'(bus.jump_position), 64'h0009_0008_0007);
        bus.jump_valid  = 1'b1;
        bus.jump_target = tgt(16'd6, 16'd5, 16'd4);
        tick();
        bus.jump_valid = 1'b0;
        check("ab_new_pos", 64'(bus.jump_position), 64'h0006_0005_0004);
        ticks_to_jump(n);
        check("ab_new_chg", 64'(n), 64'd4);
        ticks_to_idle(n);

        // Valid held high with moving target
        bus.jump_valid  = 1'b1;
        bus.jump_target = tgt(16'd1, 16'd1, 16'd1);
        tick();
        for (int i = 0; i < 13; i++) begin
            bus.jump_target = tgt(16'd2, 16'd2, 16'(i));
            tick();
            if (i == 3) begin
                check("hold_jmp_done", 64'(bus.jump_done), 64'h1);
                check("hold_jmp_pos",  64'(bus.jump_position),
                      64'h0001_0001_0001);
            end
        end
        check("hold_idle_rdy", 64'(bus.jump_ready), 64'h1);
        check("hold_idle_pos", 64'(bus.jump_position), 64'h0001_0001_0001);
        bus.jump_target = tgt(16'd4, 16'd4, 16'd4);
        tick();
        bus.jump_valid = 1'b0;
        check("hold_accept", 64'(bus.jump_position), 64'h0004_0004_0004);
        check("hold_charge", 64'(bus.jump_ready), 64'h0);
        ticks_to_jump(n);
        ticks_to_idle(n);

        // RESET and handshake in the same IDLE cycle
        bus.mode        = 4'b0001;
        bus.jump_valid  = 1'b1;
        bus.jump_target = tgt(16'd7, 16'd7, 16'd7);
        tick();
        check("rv_pm",    64'(bus.pos_mode), 64'h1);
        check("rv_abort", 64'(bus.jump_abort), 64'h0);
        check("rv_pos",   64'(bus.jump_position), 64'h0004_0004_0004);
        bus.mode       = 4'b0010;
        bus.jump_valid = 1'b0;
        tick();

        // RESET during COOLDOWN -> abort; during JUMP -> no abort
        bus.jump_valid = 1'b1;
        tick();
        bus.jump_valid = 1'b0;
        ticks_to_jump(n);
        tick();
        bus.mode = 4'b0001;
        tick();
        check("cab_pulse", 64'(bus.jump_abort), 64'h1);
        bus.mode = 4'b0010;
        tick();
        bus.jump_valid = 1'b1;
        tick();
        bus.jump_valid = 1'b0;
        ticks_to_jump(n);
        bus.mode = 4'b0001;
        tick();
        check("jab_pm",    64'(bus.pos_mode), 64'h1);
        check("jab_abort", 64'(bus.jump_abort), 64'h0);
        bus.mode = 4'b0010;
        tick();

        // Async reset mid-CHARGE discards request
        bus.jump_valid  = 1'b1;
        bus.jump_target = tgt(16'd8, 16'd8, 16'd8);
        tick();
        bus.jump_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("arst_pm",    64'(bus.pos_mode), 64'h1);
        check("arst_pos",   64'(bus.jump_position), 64'h0);
        check("arst_abort", 64'(bus.jump_abort), 64'h0);
        check("arst_busy",  64'(bus.busy), 64'h1);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_idle", 64'(bus.jump_ready), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jump_controller.md
JUMP_CONTROLLER -- requirements
Module: jump_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter K, 16: per-axis position width.
REQ-003 Parameter CHARGE_CYCLES, 4: jump charge duration in cycles; legal range 1..127.
REQ-004 Parameter COOLDOWN_CYCLES, 8: post-jump cooldown in cycles; legal range 1..255.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 mode  in  4  ship mode, one-hot: 0001 RESET, 0010 ATTACK, 0100 DEFENSE, 1000 STEALTH.
REQ-008 jump_valid  in  1  jump request valid.
REQ-009 jump_target  in  3K  requested position {Z,Y,X}; X in bits K-1:0.
REQ-010 jump_ready  out  1  request accepted when jump_valid and jump_ready are both high at a rising edge.
REQ-011 pos_mode  out  4  one-hot position-stage select: 0001 reset, 0010 normal (sublight), 0100 jump.
REQ-012 jump_position  out  3K  latched jump target driven to the position stage.
REQ-013 busy  out  1  high in INIT, CHARGE, JUMP and COOLDOWN.
REQ-014 jump_done  out  1  high for exactly the JUMP cycle.
REQ-015 jump_abort  out  1  one-cycle pulse when a charge or cooldown is cancelled by mode RESET.

Function
REQ-016 The block SHALL implement the states INIT, IDLE, CHARGE, JUMP and COOLDOWN, and all outputs SHALL be Moore outputs of state, except jump_abort, which SHALL be registered.
REQ-017 INIT: pos_mode=0001, jump_ready=0; next state IDLE unless mode==0001, in which case the block stays in INIT.
REQ-018 IDLE: pos_mode=0010, jump_ready=1, busy=0; on handshake, latch jump_target into jump_position and go to CHARGE.
REQ-019 Charge counter (8 bits) SHALL be loaded at the handshake with CHARGE_CYCLES-1, or 2*CHARGE_CYCLES-1 if mode==1000 at the handshake edge.
REQ-020 CHARGE: pos_mode=0010; the counter decrements each cycle; when the counter is 0, the next state is JUMP; the block SHALL therefore spend exactly CHARGE_CYCLES cycles (2x in STEALTH) in CHARGE.
REQ-021 A mode change during CHARGE, other than to 0001, SHALL NOT alter the loaded count.
REQ-022 JUMP: pos_mode=0100 and jump_done=1 for exactly one cycle; on exit, load COOLDOWN_CYCLES-1 into the counter and go to COOLDOWN.
REQ-023 COOLDOWN: pos_mode=0010; the counter decrements each cycle; at 0, go to IDLE.
REQ-024 jump_ready SHALL be 0 outside IDLE; jump_valid while jump_ready=0 SHALL be ignored and SHALL NOT be queued.
REQ-025 jump_target SHALL be sampled only at the handshake edge; jump_position SHALL hold its value until the next handshake or reset.
REQ-026 mode==0001 in any state other than INIT SHALL force INIT at the next edge; this takes priority over every other transition, including a same-cycle handshake in IDLE, which SHALL NOT be accepted.
REQ-027 jump_abort SHALL pulse for one cycle (the first INIT cycle) when the forced INIT comes from CHARGE or COOLDOWN; it SHALL NOT pulse when the forced INIT comes from IDLE or JUMP.
REQ-028 Any mode value that is not exactly 0001 (including 0000 and multi-hot values) SHALL be treated as non-RESET; STEALTH doubling SHALL apply only when mode==1000 exactly.
REQ-029 pos_mode SHALL always be exactly one-hot; 1000 and 0000 SHALL never be driven.

Reset
REQ-030 While rst_n=0, the outputs SHALL be: state INIT, pos_mode=0001, jump_position=0, counter=0, jump_ready=0, busy=1, jump_done=0, jump_abort=0.
REQ-031 The first rising edge after rst_n deasserts, with mode!=0001, SHALL move the block to IDLE.
REQ-032 Reset asserted mid-CHARGE or mid-JUMP SHALL take effect immediately and discard the latched request, without a jump_abort pulse.

Verification
REQ-033 Reset release, mode=0010 -> one cycle pos_mode=0001, then IDLE with pos_mode=0010, jump_ready=1, jump_position=0.
REQ-034 CHARGE_CYCLES=4, mode=0010, handshake with target {3,2,1} at edge E0 -> pos_mode=0010 for 4 cycles, then pos_mode=0100 with jump_done=1 and jump_position={3,2,1} in the cycle after edge E4, then 8 COOLDOWN cycles, then jump_ready=1.
REQ-035 Same as REQ-034 but mode=1000 at the handshake -> 8 CHARGE cycles before JUMP; switching mode to 0010 mid-charge leaves the count at 8.
REQ-036 mode=0001 during the 2nd CHARGE cycle -> next cycle pos_mode=0001, jump_abort=1 for one cycle, no JUMP cycle; after mode returns to 0010, IDLE with the new jump_position accepted only on a fresh handshake.
REQ-037 jump_valid held high through CHARGE/JUMP/COOLDOWN with a changing target -> only the first target is used; the next acceptance occurs in the first IDLE cycle.
REQ-038 mode=0001 and jump_valid=1 in the same IDLE cycle -> no handshake; INIT next cycle; jump_position unchanged; jump_abort=0.
